// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Monitors a multiplexed, active-low seven-segment bus and recovers the hex
// nibble shown on each digit. Each digit is committed only after its pattern
// has been stable for STABLE_CYCLES samples. Complete frames are offered
// downstream on a valid/ready handshake.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] hex_live,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    glyph_err
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]            STABLE_PRE = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_D      = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_BLANK  = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Returns {legal, nibble} for an active-low g..a pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0;
        case (seg)
            7'b1000000: res = {1'b1, 4'h0};
            7'b1111001: res = {1'b1, 4'h1};
            7'b0100100: res = {1'b1, 4'h2};
            7'b0110000: res = {1'b1, 4'h3};
            7'b0011001: res = {1'b1, 4'h4};
            7'b0010010: res = {1'b1, 4'h5};
            7'b0000010: res = {1'b1, 4'h6};
            7'b1111000: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0010000: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b0000011: res = {1'b1, 4'hB};
            7'b1000110: res = {1'b1, 4'hC};
            7'b0100001: res = {1'b1, 4'hD};
            7'b0000110: res = {1'b1, 4'hE};
            7'b0001110: res = {1'b1, 4'hF};
            default:    res = 5'b0;
        endcase
        return res;
    endfunction

    // Registered state
    logic [SW-1:0]           r_sample;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_hex_live;
    logic [NUM_DIGITS-1:0]   r_digit_valid;
    logic [4*NUM_DIGITS-1:0] r_frame_data;
    logic                    r_frame_valid;
    logic                    r_glyph_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    state_t                  r_state;

    // Combinational signals
    logic [SW-1:0]           w_sample;
    logic [NUM_DIGITS-1:0]   w_low;
    logic                    w_eligible;
    logic [7:0]              w_cnt_next;
    logic                    w_commit;
    logic [4:0]              w_dec;
    logic                    w_legal;
    logic [3:0]              w_nibble;
    logic                    w_illegal;
    logic [NUM_DIGITS-1:0]   w_hit;
    logic [4*NUM_DIGITS-1:0] w_hex_next;
    logic [NUM_DIGITS-1:0]   w_dvalid_next;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic                    w_mask_done;
    logic                    w_handshake;
    logic                    w_frame_load;
    logic [NUM_DIGITS-1:0]   w_mask_upd;
    logic                    w_fvalid_next;
    state_t                  w_state_next;

    assign w_sample   = {seg_in, an_in};
    // Active digit enables as a one-hot (when legal) high-true vector.
    assign w_low      = ~an_in;
    assign w_eligible = (w_low != '0) && ((w_low & (w_low - ONE_D)) == '0);

    // Stability counter: restart on change, saturate, zero when ineligible.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_eligible) begin
            w_cnt_next = 8'd0;
        end else if (w_sample != r_sample) begin
            w_cnt_next = 8'd1;
        end else if (r_cnt < STABLE_MAX) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // Commit exactly on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so a
    // pattern held for longer never commits twice.
    assign w_commit  = w_eligible && (w_sample == r_sample) && (r_cnt == STABLE_PRE);

    assign w_dec     = decode_glyph(seg_in);
    assign w_legal   = w_dec[4];
    assign w_nibble  = w_dec[3:0];
    assign w_illegal = !w_legal && (seg_in != SEG_BLANK);

    // Per-digit next values: only the enabled digit is touched by a commit;
    // blank and illegal patterns clear the valid flag but keep the nibble.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_hit[gi] = w_commit && w_low[gi];
            assign w_hex_next[4*gi +: 4] = (w_hit[gi] && w_legal) ? w_nibble
                                                                  : r_hex_live[4*gi +: 4];
            assign w_dvalid_next[gi] = w_hit[gi] ? w_legal : r_digit_valid[gi];
        end
    endgenerate

    // Mask including this cycle's commit; "done" only counts when a commit
    // is what completes it, so an already-full mask waits for the next one.
    assign w_mask_next = r_mask | w_hit;
    assign w_mask_done = w_commit && (&w_mask_next);
    assign w_handshake = r_frame_valid && frame_ready;

    // Frame FSM next-state and frame-load decision.
    always_comb begin
        w_state_next  = r_state;
        w_frame_load  = 1'b0;
        w_mask_upd    = w_mask_next;
        w_fvalid_next = r_frame_valid;
        case (r_state)
            COLLECT: begin
                if (w_mask_done) begin
                    w_frame_load  = 1'b1;
                    w_mask_upd    = '0;
                    w_fvalid_next = 1'b1;
                    w_state_next  = PENDING;
                end
            end
            PENDING: begin
                if (w_handshake) begin
                    if (w_mask_done) begin
                        // Consumed and refilled on the same edge.
                        w_frame_load  = 1'b1;
                        w_mask_upd    = '0;
                        w_fvalid_next = 1'b1;
                    end else begin
                        w_fvalid_next = 1'b0;
                        w_state_next  = COLLECT;
                    end
                end
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    // Sample, counter and per-digit result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample      <= '0;
            r_cnt         <= 8'd0;
            r_hex_live    <= '0;
            r_digit_valid <= '0;
            r_glyph_err   <= 1'b0;
        end else begin
            r_sample      <= w_sample;
            r_cnt         <= w_cnt_next;
            r_hex_live    <= w_hex_next;
            r_digit_valid <= w_dvalid_next;
            r_glyph_err   <= w_commit && w_illegal;
        end
    end

    // Frame FSM state, capture mask and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= COLLECT;
            r_mask        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_mask        <= w_mask_upd;
            r_frame_valid <= w_fvalid_next;
            if (w_frame_load) begin
                r_frame_data <= w_hex_next;
            end
        end
    end

    assign hex_live    = r_hex_live;
    assign digit_valid = r_digit_valid;
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign glyph_err   = r_glyph_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: table-driven scan scenarios with constant
// expectations, hand-written multi-cycle corner cases, then randomized
// traffic checked every cycle against a behavioural model.
module tb_seg_scan_decoder;

    localparam int ND     = 4;
    localparam int STABLE = 8;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk;
    logic          rst;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic [15:0]   hex_live;
    logic [ND-1:0] digit_valid;
    logic [15:0]   frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          glyph_err;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .hex_live    (hex_live),
        .digit_valid (digit_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .glyph_err   (glyph_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int err_seen = 0;

    // Behavioural model state (values the DUT should show after each edge).
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_hex;
    logic [3:0]  m_dv;
    logic [15:0] m_fd;
    bit          m_fv;
    bit          m_err;
    logic [3:0]  m_mask;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_hex = '0; m_dv = '0;
        m_fd = '0; m_fv = 0; m_err = 0; m_mask = '0;
    endtask

    // A digit commits when the same eligible sample has been seen exactly
    // STABLE consecutive cycles; frames follow the capture/handshake rules.
    task automatic model_step(input logic [6:0] s, input logic [3:0] a, input logic rdy);
        logic [10:0] smp;
        logic [3:0]  mask_after;
        int lows, idx, nib;
        bit elig, commit, hs, done;
        smp = {s, a};
        lows = 0; idx = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) begin lows++; idx = i; end
        elig = (lows == 1);
        if (!elig) m_run = 0;
        else if (smp == m_prev) m_run++;
        else m_run = 1;
        m_prev = smp;
        commit = elig && (m_run == STABLE);
        nib = -1;
        for (int g = 0; g < 16; g++) if (GLYPH[g] == s) nib = g;
        m_err = commit && (nib < 0) && (s != BLANK);
        hs = m_fv && rdy;
        mask_after = m_mask;
        if (commit) begin
            mask_after[idx] = 1'b1;
            m_dv[idx] = (nib >= 0);
            if (nib >= 0) m_hex[4*idx +: 4] = nib[3:0];
        end
        done = commit && (mask_after == 4'hF);
        if (done && (!m_fv || hs)) begin
            m_fd = m_hex; m_fv = 1; m_mask = '0;
        end else begin
            if (hs) m_fv = 0;
            m_mask = mask_after;
        end
    endtask

    // Drive one cycle from a negedge, let the posedge pass, return at negedge.
    task automatic tick(input logic [6:0] s, input logic [3:0] a, input logic rdy);
        seg_in = s; an_in = a; frame_ready = rdy;
        model_step(s, a, rdy);
        @(negedge clk);
        if (glyph_err === 1'b1) err_seen++;
    endtask

    task automatic show(input logic [6:0] s, input logic [3:0] a, input int hold,
                        input int gap, input logic rdy);
        for (int k = 0; k < hold; k++) tick(s, a, rdy);
        for (int k = 0; k < gap; k++) tick(BLANK, 4'hF, rdy);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_hex"},  hex_live, m_hex);
        chk({tag, "_dv"},   {12'h0, digit_valid}, {12'h0, m_dv});
        chk({tag, "_fd"},   frame_data, m_fd);
        chk({tag, "_fv"},   {15'h0, frame_valid}, {15'h0, m_fv});
        chk({tag, "_err"},  {15'h0, glyph_err}, {15'h0, m_err});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hex"}, hex_live, 16'h0);
        chk({tag, "_dv"},  {12'h0, digit_valid}, 16'h0);
        chk({tag, "_fd"},  frame_data, 16'h0);
        chk({tag, "_fv"},  {15'h0, frame_valid}, 16'h0);
        chk({tag, "_err"}, {15'h0, glyph_err}, 16'h0);
    endtask

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        int          hold;
        int          gap;
        logic        rdy;
        logic [15:0] exp_hex;
        logic [3:0]  exp_dv;
        logic        exp_fv;
        logic [15:0] exp_fd;
        int          exp_errs;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scan 1,2,3,4; bad glyph on digit 2; rescan 5..8 with ready low;
        // handshake; one more commit completes the next frame; two-low enables.
        vecs[0]  = '{7'b1111001, 4'b1110, 10, 2, 1'b0, 16'h0001, 4'b0001, 1'b0, 16'h0000, 0};
        vecs[1]  = '{7'b0100100, 4'b1101, 10, 2, 1'b0, 16'h0021, 4'b0011, 1'b0, 16'h0000, 0};
        vecs[2]  = '{7'b0110000, 4'b1011, 10, 2, 1'b0, 16'h0321, 4'b0111, 1'b0, 16'h0000, 0};
        vecs[3]  = '{7'b0011001, 4'b0111, 10, 2, 1'b0, 16'h4321, 4'b1111, 1'b1, 16'h4321, 0};
        vecs[4]  = '{7'b1111110, 4'b1011, 10, 2, 1'b0, 16'h4321, 4'b1011, 1'b1, 16'h4321, 1};
        vecs[5]  = '{7'b0010010, 4'b1110, 10, 2, 1'b0, 16'h4325, 4'b1011, 1'b1, 16'h4321, 0};
        vecs[6]  = '{7'b0000010, 4'b1101, 10, 2, 1'b0, 16'h4365, 4'b1011, 1'b1, 16'h4321, 0};
        vecs[7]  = '{7'b1111000, 4'b1011, 10, 2, 1'b0, 16'h4765, 4'b1111, 1'b1, 16'h4321, 0};
        vecs[8]  = '{7'b0000000, 4'b0111, 10, 2, 1'b0, 16'h8765, 4'b1111, 1'b1, 16'h4321, 0};
        vecs[9]  = '{BLANK,      4'b1111,  1, 0, 1'b1, 16'h8765, 4'b1111, 1'b0, 16'h4321, 0};
        vecs[10] = '{7'b0010010, 4'b1110, 10, 2, 1'b1, 16'h8765, 4'b1111, 1'b0, 16'h8765, 0};
        vecs[11] = '{7'b1000000, 4'b1100, 20, 2, 1'b0, 16'h8765, 4'b1111, 1'b0, 16'h8765, 0};

        rst = 1'b1; seg_in = BLANK; an_in = 4'hF; frame_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Table-driven scenarios
        foreach (vecs[v]) begin
            err_seen = 0;
            show(vecs[v].seg, vecs[v].an, vecs[v].hold, vecs[v].gap, vecs[v].rdy);
            $display("vec %0d: seg=%b an=%b hold=%0d -> hex=%h dv=%b fv=%b fd=%h errs=%0d",
                     v, vecs[v].seg, vecs[v].an, vecs[v].hold, hex_live, digit_valid,
                     frame_valid, frame_data, err_seen);
            chk($sformatf("tbl%0d_hex", v), hex_live, vecs[v].exp_hex);
            chk($sformatf("tbl%0d_dv", v), {12'h0, digit_valid}, {12'h0, vecs[v].exp_dv});
            chk($sformatf("tbl%0d_fv", v), {15'h0, frame_valid}, {15'h0, vecs[v].exp_fv});
            chk($sformatf("tbl%0d_fd", v), frame_data, vecs[v].exp_fd);
            chk($sformatf("tbl%0d_errs", v), 16'(err_seen), 16'(vecs[v].exp_errs));
        end

        // Stability boundary: 7 samples never commit, 8 commit on the 8th edge.
        rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        show(7'b0110000, 4'b1110, 7, 1, 1'b0);
        chk("stab7_hex", hex_live, 16'h0000);
        chk("stab7_dv", {12'h0, digit_valid}, 16'h0000);
        show(7'b0110000, 4'b1110, 7, 0, 1'b0);
        chk("stab8_pre_hex", hex_live, 16'h0000);
        tick(7'b0110000, 4'b1110, 1'b0);
        chk("stab8_hex", hex_live, 16'h0003);
        chk("stab8_dv", {12'h0, digit_valid}, 16'h0001);
        $display("stability: 7 then 8 samples of 3 on digit 0 -> hex=%h", hex_live);
        show(7'b0110000, 4'b1110, 6, 2, 1'b0);
        chk("stab_hold_hex", hex_live, 16'h0003);
        chk("stab_hold_fv", {15'h0, frame_valid}, 16'h0000);

        // Reset mid-frame: partial mask discarded, outputs clear immediately.
        show(7'b0100100, 4'b1101, 10, 2, 1'b0);
        chk("mid_hex", hex_live, 16'h0023);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        $display("async reset mid-frame -> hex=%h fv=%b", hex_live, frame_valid);
        @(negedge clk);
        rst = 1'b0;
        show(7'b0110000, 4'b1011, 10, 2, 1'b0);
        show(7'b0011001, 4'b0111, 10, 2, 1'b0);
        chk("post_rst_fv", {15'h0, frame_valid}, 16'h0000);
        chk("post_rst_hex", hex_live, 16'h4300);
        show(7'b1111001, 4'b1110, 10, 2, 1'b0);
        chk("post_rst_fv3", {15'h0, frame_valid}, 16'h0000);
        show(7'b0100100, 4'b1101, 10, 2, 1'b0);
        chk("post_rst_fv4", {15'h0, frame_valid}, 16'h0001);
        chk("post_rst_fd", frame_data, 16'h4321);
        chk_model("post_rst_model");

        // Randomized traffic against the model, checked every cycle.
        for (int ep = 0; ep < 250; ep++) begin
            logic [6:0] s;
            logic [3:0] a;
            int hold, sel;
            sel = $urandom_range(0, 99);
            if (sel < 70) begin
                a = 4'hF;
                a[$urandom_range(0, ND-1)] = 1'b0;
            end else if (sel < 85) a = 4'hF;
            else a = 4'($urandom);
            sel = $urandom_range(0, 99);
            if (sel < 70) s = GLYPH[$urandom_range(0, 15)];
            else if (sel < 80) s = BLANK;
            else s = 7'($urandom);
            hold = $urandom_range(1, 14);
            for (int k = 0; k < hold; k++) begin
                tick(s, a, 1'($urandom_range(0, 1)));
                chk_model($sformatf("rnd%0d_%0d", ep, k));
            end
            $display("rnd ep %0d: seg=%b an=%b hold=%0d -> hex=%h dv=%b fv=%b fd=%h",
                     ep, s, a, hold, hex_live, digit_valid, frame_valid, frame_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
